pps_div_regbank: RTL and testbench

//  Parametrised register bank for N_CH PPS divider channels on the host register bus.

---
 rtl/pps_div_regbank.sv | 144 ++++++++++++++
 tb/tb_pps_div_regbank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pps_div_regbank.sv
// pps_div_regbank: double-buffered register bank for N_CH PPS divider channels.
// The host writes shadow registers over a simple strobe bus. Active registers
// feed the dividers and load from shadow either immediately or on the next PPS
// pulse, so a running divider never sees a half-updated register set.
module pps_div_regbank #(
  parameter int                    N_CH       = 4,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h20,
  parameter int                    CH_STRIDE  = 16
) (
  input  logic                         i_clk_10,
  input  logic                         i_rst,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_wr,
  input  logic                         i_rd,
  input  logic                         i_pps,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_rd_valid,
  output logic [N_CH*DATA_WIDTH-1:0]   o_periodic_true,
  output logic [N_CH*DATA_WIDTH-1:0]   o_div_number,
  output logic [N_CH*4*DATA_WIDTH-1:0] o_phase_us,
  output logic [N_CH*DATA_WIDTH-1:0]   o_width_us,
  output logic [N_CH*DATA_WIDTH-1:0]   o_start,
  output logic [N_CH*DATA_WIDTH-1:0]   o_stop,
  output logic [N_CH-1:0]              o_update
);

  localparam int DW    = DATA_WIDTH;
  localparam int OFF_W = $clog2(CH_STRIDE);
  // Offsets 0..8 are the nine double-buffered registers of a channel.
  localparam int N_REG = 9;
  localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(9);
  localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(10);

  logic [DW-1:0]         shadow_reg [N_CH][N_REG];
  logic [DW-1:0]         active_reg [N_CH][N_REG];
  logic [N_CH-1:0]       pending_reg;
  logic [N_CH-1:0]       update_reg;
  logic [DW-1:0]         o_data_reg;
  logic                  rd_valid_reg;

  logic [ADDR_WIDTH-1:0] addr_rel;
  logic [ADDR_WIDTH-1:0] ch_full;
  logic [OFF_W-1:0]      off;
  logic                  addr_valid;
  logic [N_CH-1:0]       ch_hit;
  logic [N_CH-1:0]       ctrl_act;
  logic [N_CH-1:0]       load_next;
  logic [N_CH-1:0]       pending_next;
  logic [DW-1:0]         rd_value_next;
  logic                  rd_fire;

  // The full-width channel quotient is compared against N_CH so that any
  // address beyond the last channel decodes as invalid rather than aliasing.
  assign addr_rel   = i_addr - BASE_ADDR;
  assign ch_full    = addr_rel >> OFF_W;
  assign off        = addr_rel[OFF_W-1:0];
  assign addr_valid = (i_addr >= BASE_ADDR) && (ch_full < ADDR_WIDTH'(N_CH));
  assign rd_fire    = i_rd && !i_wr;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_hit[gi] = addr_valid && (ch_full == ADDR_WIDTH'(gi));
      // A CTRL write carrying any command bit takes over the channel for this
      // cycle, which is what blocks a coincident PPS commit for ARM and CANCEL.
      assign ctrl_act[gi] = i_wr && ch_hit[gi] && (off == OFF_CTRL) && (|i_data[2:0]);
      assign load_next[gi] = ctrl_act[gi] ? (!i_data[2] && i_data[1])
                                          : (i_pps && pending_reg[gi]);
      assign pending_next[gi] = ctrl_act[gi] ? (!i_data[2] && !i_data[1] && i_data[0])
                                             : (pending_reg[gi] && !i_pps);

      assign o_periodic_true[gi*DW +: DW] = active_reg[gi][0];
      assign o_div_number[gi*DW +: DW]    = active_reg[gi][1];
      assign o_phase_us[gi*4*DW +: 4*DW]  = {active_reg[gi][5], active_reg[gi][4],
                                             active_reg[gi][3], active_reg[gi][2]};
      assign o_width_us[gi*DW +: DW]      = active_reg[gi][6];
      assign o_start[gi*DW +: DW]         = active_reg[gi][7];
      assign o_stop[gi*DW +: DW]          = active_reg[gi][8];
    end
  endgenerate

  // Read mux: shadow registers and status only; CTRL and reserved read zero.
  always_comb begin
    rd_value_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_hit[c]) begin
        for (int r = 0; r < N_REG; r++) begin
          if (off == OFF_W'(r)) rd_value_next = shadow_reg[c][r];
        end
        if (off == OFF_STATUS) rd_value_next = {{(DW-1){1'b0}}, pending_reg[c]};
      end
    end
  end

  // Host writes into the shadow set; a commit in the same cycle sees the old value.
  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++)
        for (int r = 0; r < N_REG; r++)
          shadow_reg[c][r] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        for (int r = 0; r < N_REG; r++)
          if (i_wr && ch_hit[c] && (off == OFF_W'(r))) shadow_reg[c][r] <= i_data;
    end
  end

  // Active set load, pending flag and the registered per-channel update pulse.
  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++)
        for (int r = 0; r < N_REG; r++)
          active_reg[c][r] <= '0;
      pending_reg <= '0;
      update_reg  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (load_next[c])
          for (int r = 0; r < N_REG; r++)
            active_reg[c][r] <= shadow_reg[c][r];
      pending_reg <= pending_next;
      update_reg  <= load_next;
    end
  end

  // Registered read port; o_data holds between reads.
  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      o_data_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) o_data_reg <= rd_value_next;
    end
  end

  assign o_data     = o_data_reg;
  assign o_rd_valid = rd_valid_reg;
  assign o_update   = update_reg;

endmodule

// File: tb/tb_pps_div_regbank.sv
// Bench for pps_div_regbank: table of bus vectors plus hand-written sequences
// for PPS commit, immediate load, collisions, cancel, decode and reset.
module tb_pps_div_regbank;

  localparam int N_CH = 4;
  localparam int DW   = 8;

  logic                   i_clk_10 = 1'b0;
  logic                   i_rst    = 1'b1;
  logic [7:0]             i_addr   = '0;
  logic [DW-1:0]          i_data   = '0;
  logic                   i_wr     = 1'b0;
  logic                   i_rd     = 1'b0;
  logic                   i_pps    = 1'b0;
  logic [DW-1:0]          o_data;
  logic                   o_rd_valid;
  logic [N_CH*DW-1:0]     o_periodic_true;
  logic [N_CH*DW-1:0]     o_div_number;
  logic [N_CH*4*DW-1:0]   o_phase_us;
  logic [N_CH*DW-1:0]     o_width_us;
  logic [N_CH*DW-1:0]     o_start;
  logic [N_CH*DW-1:0]     o_stop;
  logic [N_CH-1:0]        o_update;

  pps_div_regbank #(
    .N_CH(N_CH), .ADDR_WIDTH(8), .DATA_WIDTH(DW), .BASE_ADDR(8'h20), .CH_STRIDE(16)
  ) dut (
    .i_clk_10(i_clk_10), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
    .i_wr(i_wr), .i_rd(i_rd), .i_pps(i_pps), .o_data(o_data), .o_rd_valid(o_rd_valid),
    .o_periodic_true(o_periodic_true), .o_div_number(o_div_number),
    .o_phase_us(o_phase_us), .o_width_us(o_width_us), .o_start(o_start),
    .o_stop(o_stop), .o_update(o_update)
  );

  always #50 i_clk_10 = ~i_clk_10;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         pps;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         tests  = 0;
  int         failed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle; inputs sampled at the next rising edge, released 1 ns after.
  task automatic cyc(input bit wr, input bit rd, input bit pps,
                     input logic [7:0] addr, input logic [7:0] data, input logic [7:0] exp_rd);
    i_wr = wr; i_rd = rd; i_pps = pps; i_addr = addr; i_data = data;
    @(posedge i_clk_10);
    if (rd && !wr) sb.push_back(exp_rd);
    #1;
    i_wr = 1'b0; i_rd = 1'b0; i_pps = 1'b0;
  endtask

  // Read-data scoreboard: every valid pulse must match the oldest expected read.
  always @(negedge i_clk_10) begin
    if (!i_rst && o_rd_valid) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL rd_valid_unexpected: got o_data=%0h with no read outstanding", o_data);
      end else begin
        chk("rd_data", {120'd0, o_data}, {120'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Bus table: shadow loads, readback, status and address decode.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h32, 8'h40, 8'h00}); // ch1 PH0
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h33, 8'h42, 8'h00}); // ch1 PH1
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h34, 8'h0F, 8'h00}); // ch1 PH2
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h35, 8'h00, 8'h00}); // ch1 PH3
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h39, 8'h01, 8'h00}); // ch1 ARM
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h32, 8'h00, 8'h40}); // ch1 PH0 shadow
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h34, 8'h00, 8'h0F}); // ch1 PH2 shadow
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h3A, 8'h00, 8'h01}); // ch1 STATUS pending
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h39, 8'h00, 8'h00}); // ch1 CTRL reads 0
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h46, 8'h33, 8'h00}); // ch2 WIDTH
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h46, 8'h00, 8'h33});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h2C, 8'hAA, 8'h00}); // ch0 reserved offset 12
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h2C, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h60, 8'h55, 8'h00}); // channel N_CH
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h60, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h1F, 8'h00, 8'h00}); // below base
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h2B, 8'h00, 8'h00}); // reserved offset 11
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h50, 8'h00, 8'h00}); // ch3 PER_TRUE

    // Power-on reset state
    repeat (3) @(posedge i_clk_10);
    @(negedge i_clk_10);
    chk("reset_o_data", {120'd0, o_data}, 128'd0);
    chk("reset_rd_valid", {127'd0, o_rd_valid}, 128'd0);
    chk("reset_phase", o_phase_us, 128'd0);
    chk("reset_update", {124'd0, o_update}, 128'd0);
    i_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].pps, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);

    // T2: armed ch1 phase stays inactive until PPS
    chk("t2_phase_before_pps", {96'd0, o_phase_us[1*32 +: 32]}, 128'd0);
    chk("t2_update_idle", {124'd0, o_update}, 128'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("t2_phase_commit", {96'd0, o_phase_us[1*32 +: 32]}, {96'd0, 32'h000F4240});
    chk("t2_update_pulse", {124'd0, o_update}, {124'd0, 4'b0010});
    cyc(1'b0, 1'b1, 1'b0, 8'h3A, 8'h00, 8'h00);
    chk("t2_update_clear", {124'd0, o_update}, 128'd0);

    // T3: immediate commit on ch3
    cyc(1'b1, 1'b0, 1'b0, 8'h51, 8'h05, 8'h00);
    chk("t3_div_before", {120'd0, o_div_number[3*8 +: 8]}, 128'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h59, 8'h02, 8'h00);
    chk("t3_div_after", {120'd0, o_div_number[3*8 +: 8]}, {120'd0, 8'h05});
    chk("t3_update", {124'd0, o_update}, {124'd0, 4'b1000});
    cyc(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h00);
    chk("t3_update_clear", {124'd0, o_update}, 128'd0);

    // T4a: ARM coincident with PPS defers the commit to the following PPS
    cyc(1'b1, 1'b0, 1'b0, 8'h20, 8'h01, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h29, 8'h01, 8'h00);
    chk("t4_arm_pps_noupd", {124'd0, o_update}, 128'd0);
    chk("t4_arm_pps_noload", {120'd0, o_periodic_true[7:0]}, 128'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h2A, 8'h00, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("t4_next_pps_load", {120'd0, o_periodic_true[7:0]}, {120'd0, 8'h01});
    chk("t4_next_pps_upd", {124'd0, o_update}, {124'd0, 4'b0001});

    // T4b: WIDTH write coincident with a commit
    cyc(1'b1, 1'b0, 1'b0, 8'h26, 8'h10, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h29, 8'h01, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h26, 8'h20, 8'h00);
    chk("t4_width_old", {120'd0, o_width_us[7:0]}, {120'd0, 8'h10});
    chk("t4_width_upd", {124'd0, o_update}, {124'd0, 4'b0001});
    cyc(1'b0, 1'b1, 1'b0, 8'h26, 8'h00, 8'h20);

    // T5: cancel and status
    cyc(1'b1, 1'b0, 1'b0, 8'h49, 8'h01, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h4A, 8'h00, 8'h01);
    cyc(1'b1, 1'b0, 1'b0, 8'h49, 8'h04, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h4A, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("t5_cancel_noupd", {124'd0, o_update}, 128'd0);
    chk("t5_cancel_width", {120'd0, o_width_us[2*8 +: 8]}, 128'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h49, 8'h01, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h49, 8'h04, 8'h00);
    chk("t5_cancel_pps_noupd", {124'd0, o_update}, 128'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h4A, 8'h00, 8'h00);

    // T6: simultaneous write and read performs only the write
    cyc(1'b1, 1'b1, 1'b0, 8'h47, 8'h77, 8'h00);
    chk("t6_wr_rd_novalid", {127'd0, o_rd_valid}, 128'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h47, 8'h00, 8'h77);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("t6_o_data_hold", {120'd0, o_data}, {120'd0, 8'h77});
    chk("t6_invalid_no_side", o_stop, 128'd0);

    // T1: asynchronous reset mid-stream with ch1 pending
    cyc(1'b1, 1'b0, 1'b0, 8'h39, 8'h01, 8'h00);
    #20;
    i_rst = 1'b1;
    #1;
    chk("t1_async_o_data", {120'd0, o_data}, 128'd0);
    chk("t1_async_phase", o_phase_us, 128'd0);
    chk("t1_async_div", {96'd0, o_div_number}, 128'd0);
    chk("t1_async_periodic", {96'd0, o_periodic_true}, 128'd0);
    chk("t1_async_width", {96'd0, o_width_us}, 128'd0);
    chk("t1_async_update", {124'd0, o_update}, 128'd0);
    @(posedge i_clk_10);
    @(negedge i_clk_10);
    i_rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("t1_pending_discarded", {124'd0, o_update}, 128'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 8'h00);
    chk("t1_rd_valid_pulse", {127'd0, o_rd_valid}, {127'd0, 1'b1});
    cyc(1'b0, 1'b1, 1'b0, 8'h32, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("t1_rd_valid_drop", {127'd0, o_rd_valid}, 128'd0);

    @(negedge i_clk_10);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
